// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default queue depth.
package uart_pkg;

    localparam int FRAME_BITS         = 8;
    localparam int IDX_W              = $clog2(FRAME_BITS);
    localparam int DEFAULT_FIFO_DEPTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo.sv
// First-word fall-through circular queue; one slot is sacrificed so full and empty
// are distinguishable from the pointers alone.
module uart_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (rd_ptr == wr_ptr);
    assign full_o  = (wr_ptr == (rd_ptr - AW'(1)));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];

    // NOTE: the storage array has no reset; emptiness is defined by the pointers,
    // which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

endmodule : uart_fifo

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled mid-bit with a programmable bit period,
// received bytes queued in a FWFT FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    input  logic        re_i,
    output logic [7:0]  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    rx_state_e               state_q, state_d;
    logic [15:0]             timer_q, timer_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    rx_meta, rx_s;
    logic                    push;
    logic                    frame_err_d;
    logic                    overrun_d;

    // Idle-high reset value keeps the FSM from seeing a false start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            index_q     <= '0;
            shift_q     <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            frame_err_o <= frame_err_d;
            overrun_o   <= overrun_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        index_d     = index_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                index_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == (baud_div_i >> 1)) begin
                    timer_d = '0;
                    index_d = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == baud_div_i) begin
                    shift_d[index_q] = rx_s;
                    timer_d          = '0;
                    index_d          = index_q + IDX_W'(1);
                    if (index_q == IDX_W'(FRAME_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == baud_div_i) begin
                    timer_d = '0;
                    if (rx_s) begin
                        // Full is judged before any same-cycle pop takes effect.
                        if (full_o) overrun_d = 1'b1;
                        else        push      = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (re_i),
        .rdata_o (data_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

endmodule : uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL expose parameter FIFO_DEPTH, default 32, receive queue entries (power of two; usable capacity FIFO_DEPTH-1).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port baud_div_i  input  16  bit period minus one, in clk_i cycles (bit period = baud_div_i+1).
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port re_i  input  1  pop request for head byte.
REQ-007 SHALL have port data_o  output  8  head byte of queue (first-word fall-through).
REQ-008 SHALL have port full_o  output  1  queue holds FIFO_DEPTH-1 bytes.
REQ-009 SHALL have port empty_o  output  1  queue holds zero bytes.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse: valid byte dropped because queue full.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); FSM uses only synchronized rx_s.
REQ-013 SHALL accept frame format: 1 start bit (0), 8 data bits LSB first, no parity, 1 stop bit (1).
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH, with a 16-bit bit-timer and 3-bit bit index.
REQ-015 IDLE: on rx_s==0 SHALL enter START with timer cleared.
REQ-016 START: when timer == baud_div_i>>1 (mid-bit), rx_s==0 -> DATA, timer cleared, index 0; rx_s==1 -> IDLE (glitch rejected, nothing pushed).
REQ-017 DATA: when timer == baud_div_i, SHALL shift rx_s into bit[index], clear timer, increment index; after index 7 -> STOP.
REQ-018 STOP: when timer == baud_div_i, rx_s==1 and not full -> push byte, -> IDLE; rx_s==1 and full -> overrun_o pulse, byte dropped, -> IDLE; rx_s==0 -> frame_err_o pulse, byte dropped, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL remain until rx_s==1, then -> IDLE (break condition yields exactly one frame_err_o).
REQ-020 Timer SHALL count +1 per cycle in START/DATA/STOP; comparisons use baud_div_i live; changing baud_div_i mid-frame is undefined.
REQ-021 Queue SHALL be circular, 5-bit (log2 FIFO_DEPTH) read/write pointers wrapping naturally; empty_o = (rd==wr); full_o = (wr == rd-1).
REQ-022 Pushed byte SHALL appear on data_o with empty_o low the cycle after the stop-bit sample.
REQ-023 re_i with empty_o low SHALL advance rd next cycle; re_i while empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL both take effect; full check for push uses pre-pop full_o.
REQ-025 data_o while empty SHALL be don't-care; verification must not check it.
REQ-026 Line-to-push latency: stop-bit mid-sample occurs 2 sync cycles plus ~9.5 bit periods after start falling edge.

Reset
REQ-027 rst_i SHALL set state IDLE, timer 0, index 0, rd=wr=0, sync flops 1, frame_err_o=0, overrun_o=0; thus empty_o=1, full_o=0.
REQ-028 Reset mid-frame SHALL discard the partial byte and all queued bytes; queue RAM contents need not be cleared.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx state enum, frame-width constant (8) and default FIFO depth.
REQ-030 Queue SHALL be a sub-module uart_fifo (FWFT, depth parameter), reusable by the transmitter.

Verification (baud_div_i=15, 16 clk/bit)
REQ-031 Send 0xA5 with stop=1 -> one push, data_o=0xA5, empty_o falls, no error pulses.
REQ-032 Low glitch of 4 cycles on idle line -> FSM returns IDLE, empty_o stays 1.
REQ-033 Frame 0x3C with stop=0, line held low 40 cycles -> exactly one frame_err_o, no push, next frame 0x81 received correctly.
REQ-034 Send 32 bytes 0x00..0x1F without popping -> full_o after 31st, byte 0x1F dropped with one overrun_o, pops return 0x00..0x1E in order.
REQ-035 Pop on same cycle as a push with 1 byte queued -> count stays 1, order preserved, pointer wrap past 31 correct.
REQ-036 rst_i asserted during DATA bit 4 -> empty_o=1 next cycle, following frame 0x5A received intact.
